// File: rtl/tx_mem_responder_pkg.sv
// Shared constants for the CPU serial bus memory responder: TX header codes,
// the RX reply start pattern and the command type decoded from a header.
package tx_mem_responder_pkg;

    localparam int unsigned NSHIFT_DEFAULT     = 2;

    localparam int unsigned TX_HEADER_READ_16  = 1;
    localparam int unsigned TX_HEADER_WRITE_8  = 2;
    localparam int unsigned TX_HEADER_WRITE_16 = 3;

    localparam int unsigned RX_START_BIT       = 1;

    typedef enum logic [1:0] {
        CMD_READ_16,
        CMD_WRITE_8,
        CMD_WRITE_16
    } cmd_e;

    // Returns 1 for a legal header code and reports the matching command.
    function automatic logic decode_header(input int unsigned code, output cmd_e cmd);
        logic ok;
        ok  = 1'b1;
        cmd = CMD_READ_16;
        case (code)
            TX_HEADER_READ_16:  cmd = CMD_READ_16;
            TX_HEADER_WRITE_8:  cmd = CMD_WRITE_8;
            TX_HEADER_WRITE_16: cmd = CMD_WRITE_16;
            default:            ok  = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tx_mem_responder_byte_ram.sv
// Byte-wide scratch memory: one synchronous write port, one asynchronous
// byte-pair read port ({mem[a+1], mem[a]}, address wraps) for the reply path
// and one asynchronous byte read port for the debug backdoor.
module byte_ram #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] pair_addr,
    output logic [15:0]          pair_data,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]           dbg_data
);

    logic [7:0]           mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] pair_addr_hi;

    assign pair_addr_hi = pair_addr + ADDR_BITS'(1);
    assign pair_data    = {mem[pair_addr_hi], mem[pair_addr]};
    assign dbg_data     = mem[dbg_addr];

    // Contents are intentionally not reset so they survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/tx_mem_responder.sv
// Memory-side endpoint of the CPU serial bus. Decodes READ_16 / WRITE_8 /
// WRITE_16 frames from tx_pins into byte_ram and returns READ_16 replies on
// rx_pins as a start pattern followed by 16 data bits, LSB first.
module tx_mem_responder
    import tx_mem_responder_pkg::*;
#(
    parameter int unsigned NSHIFT         = NSHIFT_DEFAULT,
    parameter int unsigned PAYLOAD_CYCLES = 16 / NSHIFT,
    parameter int unsigned MEM_ADDR_BITS  = 6,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSHIFT-1:0]        tx_pins,
    output logic [NSHIFT-1:0]        rx_pins,
    output logic                     busy,
    output logic                     proto_err,
    input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]               dbg_data
);

    localparam int unsigned BYTE_CYCLES = PAYLOAD_CYCLES / 2;
    localparam int unsigned CW          = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int unsigned AW_CHUNKS   = (MEM_ADDR_BITS + NSHIFT - 1) / NSHIFT;
    localparam int unsigned AW_PAD      = AW_CHUNKS * NSHIFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_LAT,
        S_REPLY_SB,
        S_REPLY
    } state_e;

    state_e                   state_q, state_d;
    cmd_e                     cmd_q, cmd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [AW_PAD-1:0]        addr_q, addr_d;
    logic [7:0]               byte_q, byte_d;
    logic [15:0]              sh_q, sh_d;
    logic [NSHIFT-1:0]        rx_q, rx_d;
    logic                     perr_q, perr_d;

    logic                     hdr_ok;
    cmd_e                     hdr_cmd;
    logic                     we;
    logic                     ram_we;
    logic [MEM_ADDR_BITS-1:0] waddr;
    logic [MEM_ADDR_BITS-1:0] a_lo;
    logic [MEM_ADDR_BITS-1:0] a_hi;
    logic [15:0]              pair_data;

    assign a_lo      = addr_q[MEM_ADDR_BITS-1:0];
    assign a_hi      = a_lo + MEM_ADDR_BITS'(1);
    assign rx_pins   = rx_q;
    assign busy      = (state_q != S_IDLE);
    assign proto_err = perr_q;

    // A write whose completing edge coincides with reset is abandoned.
    assign ram_we    = we & ~reset;

    byte_ram #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .waddr     (waddr),
        .wdata     (byte_d),
        .pair_addr (a_lo),
        .pair_data (pair_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Next-state, counter, shift registers, memory write strobe and error flag.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        rx_d    = '0;
        perr_d  = perr_q;
        we      = 1'b0;
        waddr   = a_lo;
        hdr_ok  = decode_header(32'(tx_pins), hdr_cmd);

        case (state_q)
            S_IDLE: begin
                if (tx_pins != '0) begin
                    if (hdr_ok) begin
                        state_d = S_ADDR;
                        cmd_d   = hdr_cmd;
                        cnt_d   = '0;
                    end else begin
                        perr_d  = 1'b1;
                    end
                end
            end

            S_ADDR: begin
                for (int unsigned i = 0; i < AW_CHUNKS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        addr_d[i*NSHIFT +: NSHIFT] = tx_pins;
                    end
                end
                if (cnt_q == CW'(PAYLOAD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (cmd_q == CMD_READ_16) ? S_LAT : S_WDATA;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            S_WDATA: begin
                for (int unsigned i = 0; i < PAYLOAD_CYCLES; i++) begin
                    if (cnt_q == CW'(i)) begin
                        byte_d[(i % BYTE_CYCLES)*NSHIFT +: NSHIFT] = tx_pins;
                    end
                end
                if (cnt_q == CW'(BYTE_CYCLES - 1)) begin
                    we    = 1'b1;
                    waddr = a_lo;
                    if (cmd_q == CMD_WRITE_8) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else if (cnt_q == CW'(PAYLOAD_CYCLES - 1)) begin
                    we      = 1'b1;
                    waddr   = a_hi;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            S_LAT: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    state_d = S_REPLY_SB;
                    sh_d    = pair_data;
                    rx_d    = NSHIFT'(RX_START_BIT);
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            S_REPLY_SB: begin
                state_d = S_REPLY;
                rx_d    = sh_q[NSHIFT-1:0];
                sh_d    = sh_q >> NSHIFT;
                cnt_d   = '0;
                if (tx_pins != '0) begin
                    perr_d = 1'b1;
                end
            end

            S_REPLY: begin
                if (cnt_q == CW'(PAYLOAD_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    if (tx_pins != '0) begin
                        perr_d = 1'b1;
                    end
                end else begin
                    rx_d  = sh_q[NSHIFT-1:0];
                    sh_d  = sh_q >> NSHIFT;
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_READ_16;
            cnt_q   <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_tx_mem_responder.sv
// Scoreboard bench for tx_mem_responder: directed frames push expected replies,
// a negedge monitor reassembles RX frames and compares. Extra instances cover
// READ_LATENCY=3 timing and an NSHIFT=4 build that has spare header codes.
module tb_tx_mem_responder;
    import tx_mem_responder_pkg::*;

    typedef struct {
        logic [15:0] data;
        int unsigned start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tx;
    logic [1:0]  rx;
    logic        busy;
    logic        perr;
    logic [5:0]  dbg_a;
    logic [7:0]  dbg_d;

    logic        u3_en;
    logic [1:0]  tx3;
    logic [1:0]  rx3;
    logic        busy3;
    logic        perr3;
    logic [5:0]  dbg_a3;
    logic [7:0]  dbg_d3;

    logic [3:0]  tx4;
    logic [3:0]  rx4;
    logic        busy4;
    logic        perr4;
    logic [7:0]  dbg_a4;
    logic [7:0]  dbg_d4;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc  = 0;
    int unsigned c0   = 0;
    exp_t        q[$];

    assign tx3 = u3_en ? tx : 2'b00;

    tx_mem_responder u_dut (
        .clk(clk), .reset(rst), .tx_pins(tx), .rx_pins(rx), .busy(busy),
        .proto_err(perr), .dbg_addr(dbg_a), .dbg_data(dbg_d)
    );

    tx_mem_responder #(.READ_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst), .tx_pins(tx3), .rx_pins(rx3), .busy(busy3),
        .proto_err(perr3), .dbg_addr(dbg_a3), .dbg_data(dbg_d3)
    );

    tx_mem_responder #(.NSHIFT(4), .MEM_ADDR_BITS(8)) u_n4 (
        .clk(clk), .reset(rst), .tx_pins(tx4), .rx_pins(rx4), .busy(busy4),
        .proto_err(perr4), .dbg_addr(dbg_a4), .dbg_data(dbg_d4)
    );

    always #5 clk = ~clk;

    // Free-running cycle index used to time reply start cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic [1:0] v);
        @(posedge clk);
        #1 tx = v;
    endtask

    task automatic tick4(input logic [3:0] v);
        @(posedge clk);
        #1 tx4 = v;
    endtask

    task automatic send_ha(input int unsigned hdr, input logic [15:0] a);
        tick(2'(hdr));
        c0 = cyc;
        for (int i = 0; i < 8; i++) tick(a[i*2 +: 2]);
    endtask

    task automatic write16(input logic [15:0] a, input logic [15:0] d);
        send_ha(TX_HEADER_WRITE_16, a);
        for (int i = 0; i < 8; i++) tick(d[i*2 +: 2]);
    endtask

    task automatic write8(input logic [15:0] a, input logic [7:0] d);
        send_ha(TX_HEADER_WRITE_8, a);
        for (int i = 0; i < 4; i++) tick(d[i*2 +: 2]);
    endtask

    // Issues a READ_16 and idles through T18; the next frame may start at T19.
    task automatic read16(input logic [15:0] a, input logic [15:0] exp,
                          input int unsigned rst_at, input bit hdr_last, input bit chk3);
        exp_t e;
        send_ha(TX_HEADER_READ_16, a);
        e.data  = exp;
        e.start = c0 + 10;
        q.push_back(e);
        for (int n = 9; n <= 18; n++) begin
            tick((n == 18 && hdr_last) ? 2'(TX_HEADER_READ_16) : 2'b00);
            rst = (n == rst_at);
            @(negedge clk);
            if (chk3 && n <= 12) check($sformatf("lat3_rx_T%0d", n), rx3, (n == 12) ? 1 : 0);
            if (rst_at != 0 && n == rst_at + 1) begin
                check("rst_mid_reply_busy", busy, 0);
                check("rst_mid_reply_rx", rx, 0);
                check("rst_mid_reply_perr", perr, 0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic dbg_check(input logic [5:0] a, input logic [7:0] exp);
        dbg_a = a;
        #1 check($sformatf("dbg[0x%0h]", a), dbg_d, exp);
    endtask

    // Monitor: reassembles each reply frame and compares with the scoreboard.
    initial begin : monitor
        bit          coll;
        int          k;
        logic [15:0] w;
        int unsigned sc;
        exp_t        e;
        coll = 1'b0;
        k    = 0;
        w    = '0;
        sc   = 0;
        forever begin
            @(negedge clk);
            if (!coll) begin
                if (!rst) begin
                    if (rx == 2'b01) begin
                        coll = 1'b1;
                        k    = 0;
                        sc   = cyc;
                    end else if (rx != 2'b00) begin
                        check("rx_outside_reply", rx, 0);
                    end
                end
            end else begin
                w[k*2 +: 2] = rx;
                k++;
                if (k == 8) begin
                    coll = 1'b0;
                    if (q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL reply_unexpected: got data 0x%0h, expected no reply", w);
                    end else begin
                        e = q.pop_front();
                        check("reply_start_cycle", sc, e.start);
                        check("reply_data", w, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] w4;
        int          drain;
        rst    = 1'b1;
        tx     = 2'b00;
        tx4    = 4'h0;
        u3_en  = 1'b1;
        dbg_a  = '0;
        dbg_a3 = '0;
        dbg_a4 = '0;
        w4     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx", rx, 0);
        check("reset_busy", busy, 0);
        check("reset_perr", perr, 0);
        rst = 1'b0;

        // WRITE_16 a=0x0010 d=0x1234, back-to-back READ_16 of the same word.
        write16(16'h0010, 16'h1234);
        tick(2'b00);
        @(negedge clk);
        check("w16_idle_T17", busy, 0);
        dbg_check(6'h10, 8'h34);
        dbg_check(6'h11, 8'h12);
        read16(16'h0010, 16'h1234, 0, 1'b0, 1'b1);
        u3_en = 1'b0;

        // WRITE_8 neighbours stay untouched.
        write8(16'h0020, 8'h5A);
        write8(16'h0022, 8'hC3);
        write8(16'h0021, 8'hA5);
        tick(2'b00);
        @(negedge clk);
        check("w8_idle", busy, 0);
        dbg_check(6'h21, 8'hA5);
        dbg_check(6'h20, 8'h5A);
        dbg_check(6'h22, 8'hC3);

        // Address wrap and aliasing of upper address bits.
        write8(16'h003F, 8'h11);
        write8(16'h0000, 8'h22);
        read16(16'h003F, 16'h2211, 0, 1'b0, 1'b0);
        read16(16'hFFBF, 16'h2211, 0, 1'b0, 1'b0);
        check("perr_payload_not_header", perr, 0);

        // Header during the last reply cycle: flagged and dropped.
        read16(16'h0010, 16'h1234, 0, 1'b1, 1'b0);
        tick(2'b00);
        @(negedge clk);
        check("reply_hdr_dropped_busy", busy, 0);
        check("reply_hdr_perr", perr, 1);

        // Reset during the 4th reply data cycle truncates the reply to the low byte.
        read16(16'h003F, 16'h0011, 14, 1'b0, 1'b0);
        read16(16'h003F, 16'h2211, 0, 1'b0, 1'b0);
        dbg_check(6'h3F, 8'h11);
        dbg_check(6'h00, 8'h22);

        drain = 0;
        while (q.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", q.size(), 0);

        // NSHIFT=4 build: illegal header, then a full write/read round trip.
        tick4(4'h5);
        tick4(4'h0);
        @(negedge clk);
        check("n4_illegal_perr", perr4, 1);
        check("n4_illegal_busy", busy4, 0);
        tick4(4'h3);
        tick4(4'h5); tick4(4'h0); tick4(4'h0); tick4(4'h0);
        tick4(4'hF); tick4(4'hE); tick4(4'hE); tick4(4'hB);
        tick4(4'h0);
        @(negedge clk);
        check("n4_w16_idle", busy4, 0);
        dbg_a4 = 8'h05;
        #1 check("n4_dbg[0x05]", dbg_d4, 8'hEF);
        dbg_a4 = 8'h06;
        #1 check("n4_dbg[0x06]", dbg_d4, 8'hBE);
        tick4(4'h1);
        tick4(4'h5); tick4(4'h0); tick4(4'h0); tick4(4'h0);
        for (int n = 5; n <= 11; n++) begin
            tick4(4'h0);
            @(negedge clk);
            if (n == 5)  check("n4_lat_rx", rx4, 0);
            if (n == 6)  check("n4_start", rx4, 1);
            if (n >= 7 && n <= 10) w4[(n-7)*4 +: 4] = rx4;
            if (n == 11) check("n4_reply_done", busy4, 0);
        end
        check("n4_reply_data", w4, 16'hBEEF);
        check("n4_perr_sticky", perr4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
